// File: rtl/branch_ctrl.sv
// Branch prediction and redirect controller: direct-mapped target table with
// 2-bit counters, mispredict detection, redirect/flush sequencing, perf counters.
module branch_ctrl #(
    parameter int unsigned IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic [2:0]  ex_br_type,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] br_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int unsigned ENTRIES = 1 << IDX_W;
    localparam int unsigned TAG_W   = 30 - IDX_W;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic             tbl_valid  [ENTRIES];
    logic [TAG_W-1:0] tbl_tag    [ENTRIES];
    logic [31:0]      tbl_target [ENTRIES];
    logic [1:0]       tbl_ctr    [ENTRIES];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic             if_hit, ex_hit;
    logic             is_br, is_jump, taken_eff, resolve, mispred;

    // Fetch-side lookup from registered table contents only (no write bypass)
    assign if_idx      = if_pc[IDX_W+1:2];
    assign if_hit      = tbl_valid[if_idx] && (tbl_tag[if_idx] == if_pc[31:IDX_W+2]);
    assign pred_taken  = if_hit && tbl_ctr[if_idx][1];
    assign pred_target = pred_taken ? tbl_target[if_idx] : if_pc + 32'd4;

    assign ex_idx    = ex_pc[IDX_W+1:2];
    assign ex_hit    = tbl_valid[ex_idx] && (tbl_tag[ex_idx] == ex_pc[31:IDX_W+2]);
    assign is_br     = (ex_br_type != 3'b000);
    assign is_jump   = (ex_br_type == 3'b111);
    assign taken_eff = is_br && ex_br_taken;
    assign resolve   = ex_valid && !ex_stall && (state == RUN);
    assign mispred   = (ex_pred_taken != taken_eff) ||
                       (ex_pred_taken && taken_eff && (ex_pred_target != ex_target));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Redirect is asserted in the resolution cycle; FLUSH covers the fetch already in flight
    always_comb begin
        state_nxt   = state;
        redirect    = 1'b0;
        flush       = 1'b0;
        redirect_pc = taken_eff ? ex_target : ex_pc + 32'd4;
        case (state)
            RUN: begin
                if (resolve && mispred && !rst) begin
                    redirect  = 1'b1;
                    flush     = 1'b1;
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                flush     = !rst;
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tbl_valid[i]  <= 1'b0;
                tbl_tag[i]    <= '0;
                tbl_target[i] <= '0;
                tbl_ctr[i]    <= 2'b01;
            end
        end else if (resolve) begin
            if (is_jump) begin
                tbl_valid[ex_idx]  <= 1'b1;
                tbl_tag[ex_idx]    <= ex_pc[31:IDX_W+2];
                tbl_target[ex_idx] <= ex_target;
                tbl_ctr[ex_idx]    <= 2'b11;
            end else if (is_br && ex_hit) begin
                if (taken_eff) begin
                    tbl_target[ex_idx] <= ex_target;
                    if (tbl_ctr[ex_idx] != 2'b11) tbl_ctr[ex_idx] <= tbl_ctr[ex_idx] + 2'd1;
                end else if (tbl_ctr[ex_idx] != 2'b00) begin
                    tbl_ctr[ex_idx] <= tbl_ctr[ex_idx] - 2'd1;
                end
            end else if (is_br && taken_eff) begin
                tbl_valid[ex_idx]  <= 1'b1;
                tbl_tag[ex_idx]    <= ex_pc[31:IDX_W+2];
                tbl_target[ex_idx] <= ex_target;
                tbl_ctr[ex_idx]    <= 2'b10;
            end else if (!is_br && ex_pred_taken) begin
                tbl_valid[ex_idx] <= 1'b0;
            end
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt      <= '0;
            mispred_cnt <= '0;
        end else if (resolve) begin
            if (is_br && (br_cnt != 32'hFFFF_FFFF)) br_cnt <= br_cnt + 32'd1;
            if (mispred && (mispred_cnt != 32'hFFFF_FFFF)) mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl with hand-computed expectations.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_stall, ex_br_taken, ex_pred_taken;
    logic [2:0]  ex_br_type;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        redirect, flush;
    logic [31:0] redirect_pc, br_cnt, mispred_cnt;

    int checks   = 0;
    int failures = 0;

    branch_ctrl #(.IDX_W(4)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_br_type(ex_br_type),
        .ex_br_taken(ex_br_taken), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
        .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] ty, input logic tk, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        ex_valid = 1'b1; ex_br_type = ty; ex_br_taken = tk; ex_pc = pc;
        ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
        #1;
    endtask

    task automatic idle;
        ex_valid = 1'b0; ex_br_type = 3'b000; ex_br_taken = 1'b0; ex_pred_taken = 1'b0;
        #1;
    endtask

    task automatic query(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        if_pc = pc;
        #1;
        chk({tag, "_ptk"}, 32'(pred_taken), 32'(tk));
        chk({tag, "_ptgt"}, pred_target, tgt);
    endtask

    task automatic ctl(input string tag, input logic rd, input logic [31:0] rpc, input logic fl);
        chk({tag, "_redir"}, 32'(redirect), 32'(rd));
        if (rd) chk({tag, "_rpc"}, redirect_pc, rpc);
        chk({tag, "_flush"}, 32'(flush), 32'(fl));
    endtask

    task automatic cnts(input string tag, input logic [31:0] b, input logic [31:0] m);
        chk({tag, "_br"}, br_cnt, b);
        chk({tag, "_mis"}, mispred_cnt, m);
    endtask

    initial begin
        rst = 1'b1; ex_stall = 1'b0; if_pc = 32'h100;
        ex_pc = 32'h0; ex_target = 32'h0; ex_pred_target = 32'h0;
        idle();
        #2;
        query("rst", 32'h100, 1'b0, 32'h104);
        cnts("rst", 0, 0);
        ctl("rst", 1'b0, 0, 1'b0);
        step();
        rst = 1'b0;
        step();

        // BEQ 0x100 -> 0x80 taken, predicted not-taken: allocate + redirect
        drive(3'b001, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
        ctl("beq1", 1'b1, 32'h80, 1'b1);
        query("beq1_nobypass", 32'h100, 1'b0, 32'h104);
        step();
        // FLUSH cycle: live mispredicting input must be ignored
        drive(3'b001, 1'b1, 32'h140, 32'h600, 1'b0, 32'h144);
        ctl("beq1_fl", 1'b0, 0, 1'b1);
        cnts("beq1", 1, 1);
        query("beq1_trained", 32'h100, 1'b1, 32'h80);
        step();
        idle();
        ctl("beq1_after", 1'b0, 0, 1'b0);
        cnts("fl_ignored", 1, 1);

        // Not-taken twice: ctr 10 -> 01 -> 00
        drive(3'b001, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80);
        ctl("nt1", 1'b1, 32'h104, 1'b1);
        step();
        idle();
        query("nt1_pred", 32'h100, 1'b0, 32'h104);
        cnts("nt1", 2, 2);
        step();
        drive(3'b001, 1'b0, 32'h100, 32'h80, 1'b0, 32'h104);
        ctl("nt2", 1'b0, 0, 1'b0);
        step();
        idle();
        cnts("nt2", 3, 2);
        // One taken from 00 reaches 01, still predicting not-taken
        drive(3'b001, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
        ctl("tk_from00", 1'b1, 32'h80, 1'b1);
        step();
        idle();
        query("ctr01", 32'h100, 1'b0, 32'h104);
        step();

        // Jump 0x200 -> 0x300 correctly predicted (aliases index 0 of 0x100)
        drive(3'b111, 1'b1, 32'h200, 32'h300, 1'b1, 32'h300);
        ctl("jmp_ok", 1'b0, 0, 1'b0);
        step();
        idle();
        cnts("jmp_ok", 5, 3);
        query("jmp_pred", 32'h200, 1'b1, 32'h300);
        query("tag_miss", 32'h100, 1'b0, 32'h104);

        // Right direction, wrong target
        drive(3'b111, 1'b1, 32'h200, 32'h340, 1'b1, 32'h300);
        ctl("tgt_wrong", 1'b1, 32'h340, 1'b1);
        step();
        idle();
        query("tgt_rewr", 32'h200, 1'b1, 32'h340);
        cnts("tgt_wrong", 6, 4);
        step();

        // Stalled mispredict deferred until stall drops
        ex_stall = 1'b1;
        drive(3'b010, 1'b1, 32'h104, 32'h500, 1'b0, 32'h108);
        ctl("stall", 1'b0, 0, 1'b0);
        step();
        cnts("stall", 6, 4);
        ctl("stall2", 1'b0, 0, 1'b0);
        ex_stall = 1'b0;
        #1;
        ctl("unstall", 1'b1, 32'h500, 1'b1);
        step();
        idle();
        cnts("unstall", 7, 5);
        ctl("fl_pre_rst", 1'b0, 0, 1'b1);

        // Reset during FLUSH drops flush at once and clears table/counters
        rst = 1'b1;
        #1;
        chk("rst_in_flush", 32'(flush), 32'd0);
        cnts("rst2", 0, 0);
        query("rst2_tbl", 32'h200, 1'b0, 32'h204);
        step();
        rst = 1'b0;
        step();

        // Alias hit on a non-branch: mispredict to pc+4, br_cnt untouched
        drive(3'b000, 1'b1, 32'h200, 32'h900, 1'b1, 32'h340);
        ctl("alias", 1'b1, 32'h204, 1'b1);
        step();
        idle();
        cnts("alias", 0, 1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
